// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, framing constants, majority-vote helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 9;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned SAMPLE_W   = 4;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Two-of-three vote over the mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator, shared by the UART receiver and transmitter.
// Ports:
//   sysclk  - system clock
//   Reset_n - asynchronous active-low reset
//   clr     - restart the divider so the next tick lands a full period later
//   tick    - registered one-cycle pulse every DIV sysclk cycles
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic sysclk,
    input  logic Reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Divider counter 0..DIV-1; tick issued as the counter wraps.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 16x oversampling, mid-bit majority vote, framing and overrun flags.
// Ports:
//   sysclk, Reset_n       - clock, asynchronous active-low reset
//   UART_IN               - asynchronous serial line, idle high
//   rx_data / rx_valid    - last received byte and its unread flag (cleared by rx_ack)
//   rx_ack                - one-cycle read strobe
//   frame_err / overrun   - sticky error flags, cleared by err_clr
//   err_clr               - one-cycle error clear strobe
//   rx_busy               - receiver is inside a frame
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       Reset_n,
    input  logic       UART_IN,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       rx_busy
);

    localparam logic [SAMPLE_W-1:0] S_MID  = SAMPLE_W'(MID_SAMPLE);
    localparam logic [SAMPLE_W-1:0] S_PRE1 = SAMPLE_W'(MID_SAMPLE - 1);
    localparam logic [SAMPLE_W-1:0] S_PRE2 = SAMPLE_W'(MID_SAMPLE - 2);
    localparam logic [SAMPLE_W-1:0] S_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]    I_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e            state;
    logic [1:0]           sync;
    logic                 line_prev;
    logic [SAMPLE_W-1:0]  s_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 bit_done;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 deliver;
    logic                 tick;

    logic line_c;
    logic start_c;
    logic maj_c;
    logic mid_c;
    logic last_c;

    assign line_c  = sync[1];
    assign start_c = (state == IDLE) && line_prev && !line_c;
    assign maj_c   = maj3(samp_a, samp_b, line_c);
    assign mid_c   = tick && (s_cnt == S_MID);
    assign last_c  = tick && (s_cnt == S_LAST);

    // Divider is restarted on the start edge so sampling phase tracks the frame.
    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .sysclk (sysclk),
        .Reset_n(Reset_n),
        .clr    (start_c),
        .tick   (tick)
    );

    // Synchroniser, sampling, FSM, shift register and output registers.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            sync      <= 2'b11;
            line_prev <= 1'b1;
            s_cnt     <= '0;
            bit_idx   <= '0;
            bit_done  <= 1'b0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            shreg     <= '0;
            deliver   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            sync      <= {sync[0], UART_IN};
            line_prev <= line_c;
            deliver   <= 1'b0;

            if (tick) begin
                s_cnt <= s_cnt + SAMPLE_W'(1);
                if (s_cnt == S_PRE2) samp_a <= line_c;
                if (s_cnt == S_PRE1) samp_b <= line_c;
            end

            // Clear first so an error raised this cycle still wins.
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= START;
                        rx_busy  <= 1'b1;
                        s_cnt    <= '0;
                        bit_idx  <= '0;
                        bit_done <= 1'b0;
                    end
                end
                START: begin
                    if (mid_c) begin
                        if (maj_c) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (mid_c) begin
                        shreg[bit_idx] <= maj_c;
                        bit_done       <= 1'b1;
                    end
                    // The first wrap after START closes the start bit, not a data bit.
                    if (last_c && bit_done) begin
                        bit_done <= 1'b0;
                        if (bit_idx == I_LAST) state <= STOP;
                        else bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    if (mid_c) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (maj_c) deliver   <= 1'b1;
                        else       frame_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase

            // Hand-off to the CPU register; a read in the same cycle frees the slot.
            if (deliver) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 16 sysclk per bit.
module tb_uart_rx_core;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int FRAME = 160;

    logic       sysclk = 1'b0;
    logic       Reset_n;
    logic       UART_IN;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       rx_busy;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .sysclk   (sysclk),
        .Reset_n  (Reset_n),
        .UART_IN  (UART_IN),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr),
        .rx_busy  (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model of the CPU-visible register state.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    logic       m_ferr;

    // Per-frame observations.
    logic busy_mid;
    logic [7:0] snap_data;
    logic snap_valid, snap_ferr, snap_ovr, snap_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  32'(rx_data),   32'(m_data));
        chk({tag, ".valid"}, 32'(rx_valid),  32'(m_valid));
        chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
        chk({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
        chk({tag, ".busy"},  32'(rx_busy),   32'(0));
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (m_valid) m_ovr = 1'b1;
        else begin
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        UART_IN = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle strobes on rx_ack / err_clr, mirrored into the model.
    task automatic pulse(input logic a, input logic c);
        rx_ack  = a;
        err_clr = c;
        step();
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        if (a) m_valid = 1'b0;
        if (c) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    // Drive one 8N1 frame (16 cycles/bit) followed by idle cycles. Optional rx_ack
    // and reset pulse at given cycle indices; reports the cycle where rx_valid rose.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_n,
                              input int ack_at, input int rst_at, output int first_valid);
        logic [9:0] bits;
        logic prev_v;
        bits = {stop_bit, b, 1'b0};
        prev_v = rx_valid;
        first_valid = -1;
        for (int i = 0; i < FRAME + idle_n; i++) begin
            UART_IN = (i < FRAME) ? bits[i / 16] : 1'b1;
            rx_ack  = (i == ack_at);
            if (rst_at >= 0 && i == rst_at) Reset_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 3) Reset_n = 1'b1;
            step();
            if (i == 80) busy_mid = rx_busy;
            if (rst_at >= 0 && i == rst_at) begin
                snap_data = rx_data; snap_valid = rx_valid; snap_ferr = frame_err;
                snap_ovr = overrun; snap_busy = rx_busy;
            end
            if (first_valid < 0 && rx_valid && !prev_v) first_valid = i;
            prev_v = rx_valid;
        end
        rx_ack  = 1'b0;
        UART_IN = 1'b1;
    endtask

    initial begin
        int lat;
        int fv;
        logic [7:0] b;
        logic ok;
        Reset_n = 1'b0; UART_IN = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
        model_reset();
        idle(3);
        check_all("reset");
        Reset_n = 1'b1;
        idle(10);

        // 1: single byte, then read
        send_frame(8'hA5, 1'b1, 20, -1, -1, lat);
        model_frame(8'hA5, 1'b1);
        chk("t1.lat_window", 32'(lat >= 145 && lat <= 170), 32'(1));
        chk("t1.busy_mid", 32'(busy_mid), 32'(1));
        check_all("t1");
        pulse(1'b1, 1'b0);
        chk("t1.ack_clears", 32'(rx_valid), 32'(0));

        // 2: back-to-back without read -> overrun, keeps first byte
        send_frame(8'h3C, 1'b1, 0, -1, -1, fv);
        model_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1, 20, -1, -1, fv);
        model_frame(8'hC3, 1'b1);
        check_all("t2");
        pulse(1'b0, 1'b1);
        check_all("t2.clr");
        pulse(1'b1, 1'b0);

        // 3: read strobe coincides with delivery of the next byte
        send_frame(8'h11, 1'b1, 20, -1, -1, fv);
        model_frame(8'h11, 1'b1);
        send_frame(8'h7E, 1'b1, 20, lat, -1, fv);
        m_data = 8'h7E; m_valid = 1'b1;
        check_all("t3");
        pulse(1'b1, 1'b0);

        // 4: bad stop bit
        send_frame(8'h55, 1'b0, 20, -1, -1, fv);
        model_frame(8'h55, 1'b0);
        check_all("t4");
        pulse(1'b0, 1'b1);

        // 5: short glitch is rejected, then a clean byte
        UART_IN = 1'b0;
        for (int i = 0; i < 4; i++) step();
        idle(30);
        check_all("t5.glitch");
        send_frame(8'h01, 1'b1, 20, -1, -1, fv);
        model_frame(8'h01, 1'b1);
        check_all("t5.byte");

        // 6: reset mid-frame (data bit 4 of 8'hFF), then recover
        send_frame(8'hFF, 1'b1, 20, -1, 85, fv);
        chk("t6.rst_data",  32'(snap_data),  32'(0));
        chk("t6.rst_valid", 32'(snap_valid), 32'(0));
        chk("t6.rst_busy",  32'(snap_busy),  32'(0));
        chk("t6.rst_ferr",  32'(snap_ferr),  32'(0));
        chk("t6.rst_ovr",   32'(snap_ovr),   32'(0));
        model_reset();
        check_all("t6.after");
        send_frame(8'h81, 1'b1, 20, -1, -1, fv);
        model_frame(8'h81, 1'b1);
        check_all("t6.byte");

        // Randomised traffic: bytes, bad stops, back-to-back, reads and clears
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(7) != 0);
            if (ok && $urandom_range(3) == 0) begin
                send_frame(b, 1'b1, 0, -1, -1, fv);
                model_frame(b, 1'b1);
            end else begin
                send_frame(b, ok, int'($urandom_range(20, 40)), -1, -1, fv);
                model_frame(b, ok);
                pulse(1'($urandom_range(1)), 1'($urandom_range(3) == 0));
                check_all("rand");
            end
        end
        idle(30);
        check_all("rand.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
